// File: rtl/riscy_core_p_if.sv
// Memory-side bus of the RISC-Y core: instruction fetch and data access
// channels, each a req/ack handshake so wait-state memories can attach.
interface riscy_core_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int PC_W   = 5
) ();
    localparam int INSTR_W = 4 + DATA_W;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    logic               dmem_req;
    logic               dmem_we;
    logic [ADDR_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/riscy_core_p.sv
// Parametrised multi-cycle RISC-Y accumulator core.
// FETCH -> DECODE -> [MEM] -> EXEC, with HALT as a sink state.
// Instruction and data memories live behind the req/ack bus interface;
// NUM_PORTS independent input/output channels replace a bidirectional port.
module riscy_core_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int PC_W      = 5,
    parameter int NUM_PORTS = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    riscy_core_p_if.master              bus,
    input  logic [NUM_PORTS*DATA_W-1:0] io_in,
    output logic [NUM_PORTS*DATA_W-1:0] io_out,
    output logic [NUM_PORTS-1:0]        io_wstb,
    output logic                        halted
);
    localparam int INSTR_W = 4 + DATA_W;
    localparam int PSEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_INP  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_ADDI = 4'hD;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   a;
    logic                z;
    logic                c;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   mdr;
    logic                imem_req_r;
    logic                dmem_req_r;
    logic                dmem_we_r;
    logic [NUM_PORTS-1:0] wstb_r;
    logic                halted_r;
    logic [DATA_W-1:0]   out_ch [NUM_PORTS];
    logic [DATA_W-1:0]   in_ch  [NUM_PORTS];

    logic [3:0]          op;
    logic [DATA_W-1:0]   operand;
    logic [PSEL_W-1:0]   port_sel;
    logic                op_is_mem;
    logic                take_jmp;

    logic                a_wr;
    logic                c_wr;
    logic [DATA_W-1:0]   a_nxt;
    logic                c_nxt;
    logic [DATA_W:0]     sum;

    assign op        = ir[INSTR_W-1 -: 4];
    assign operand   = ir[DATA_W-1:0];
    assign port_sel  = (NUM_PORTS > 1) ? operand[PSEL_W-1:0] : '0;
    assign op_is_mem = op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_XOR};
    assign take_jmp  = (op == OP_JMP) || ((op == OP_JZ) && z) || ((op == OP_JC) && c);

    // The fetch address is the PC itself; data address/write data come
    // straight from the operand and accumulator, both stable through MEM.
    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = operand[ADDR_W-1:0];
    assign bus.dmem_wdata = a;
    assign io_wstb        = wstb_r;
    assign halted         = halted_r;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ports
        assign in_ch[k]                   = io_in[k*DATA_W +: DATA_W];
        assign io_out[k*DATA_W +: DATA_W] = out_ch[k];
    end

    // Execute-stage result: new accumulator/carry and which of them are written.
    always_comb begin
        a_wr  = 1'b0;
        c_wr  = 1'b0;
        a_nxt = a;
        c_nxt = c;
        sum   = '0;
        case (op)
            OP_LDA: begin
                a_wr  = 1'b1;
                a_nxt = mdr;
            end
            OP_LDI: begin
                a_wr  = 1'b1;
                a_nxt = operand;
            end
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, mdr};
                a_wr  = 1'b1;
                c_wr  = 1'b1;
                a_nxt = sum[DATA_W-1:0];
                c_nxt = sum[DATA_W];
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                sum   = {1'b0, a} - {1'b0, mdr};
                a_wr  = 1'b1;
                c_wr  = 1'b1;
                a_nxt = sum[DATA_W-1:0];
                c_nxt = sum[DATA_W];
            end
            OP_AND: begin
                a_wr  = 1'b1;
                a_nxt = a & mdr;
            end
            OP_XOR: begin
                a_wr  = 1'b1;
                a_nxt = a ^ mdr;
            end
            OP_INP: begin
                a_wr  = 1'b1;
                a_nxt = in_ch[port_sel];
            end
            OP_ADDI: begin
                sum   = {1'b0, a} + {1'b0, operand};
                a_wr  = 1'b1;
                c_wr  = 1'b1;
                a_nxt = sum[DATA_W-1:0];
                c_nxt = sum[DATA_W];
            end
            default: ;
        endcase
    end

    // Control FSM with all architectural registers and registered bus outputs.
    // imem_req is raised one cycle after entering FETCH from reset, so an ack
    // left over from before reset can never be mistaken for a fetch.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_FETCH;
            pc         <= '0;
            a          <= '0;
            z          <= 1'b0;
            c          <= 1'b0;
            ir         <= '0;
            mdr        <= '0;
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            wstb_r     <= '0;
            halted_r   <= 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                out_ch[k] <= '0;
            end
        end else begin
            wstb_r <= '0;
            case (state)
                S_FETCH: begin
                    if (!imem_req_r) begin
                        imem_req_r <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir         <= bus.imem_data;
                        pc         <= pc + PC_W'(1);
                        imem_req_r <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op_is_mem) begin
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= (op == OP_STA);
                        state      <= S_MEM;
                    end else if (op == OP_HLT) begin
                        halted_r   <= 1'b1;
                        state      <= S_HALT;
                    end else begin
                        state      <= S_EXEC;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        if (!dmem_we_r) begin
                            mdr <= bus.dmem_rdata;
                        end
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (a_wr) begin
                        a <= a_nxt;
                        z <= (a_nxt == '0);
                    end
                    if (c_wr) begin
                        c <= c_nxt;
                    end
                    if (op == OP_OUT) begin
                        out_ch[port_sel] <= a;
                        wstb_r[port_sel] <= 1'b1;
                    end
                    if (take_jmp) begin
                        pc <= operand[PC_W-1:0];
                    end
                    imem_req_r <= 1'b1;
                    state      <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscy_core_p.sv
// Testbench for riscy_core_p: behavioural memories with random wait states,
// an instruction-level reference model, directed programs and random programs.
module tb_riscy_core_p;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 7;
    localparam int PC_W      = 5;
    localparam int NUM_PORTS = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [1:0]  io_wstb;
    logic        halted;

    riscy_core_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

    riscy_core_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .NUM_PORTS(NUM_PORTS)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .io_in(io_in),
        .io_out(io_out),
        .io_wstb(io_wstb),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    int tests;
    int fails;
    int cyc;

    logic [11:0] rom [32];
    logic [7:0]  ram [128];

    // memory responder state and wait-state configuration
    int   iw_max, iw_fix, dw_max, dw_fix;
    bit   i_pend, d_pend, d_we;
    int   i_wait, d_wait, i_addr, d_addr;
    logic [1:0] prev_wstb;
    int   wstb_cycles;
    int   last_wstb;

    // DUT observations
    int got_fetch[$];
    int got_fcyc[$];
    int got_out[$];
    int got_wr[$];

    // reference model results
    int exp_fetch[$];
    int exp_gap[$];
    int exp_out[$];
    int exp_wr[$];
    bit exp_halt;
    int exp_io[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // Instruction-set level model: runs n instructions (or until HLT).
    task automatic model_run(input int n);
        int pc, a, z, c, op, opd, m, s, p, ea;
        logic [7:0] mram [128];
        for (int k = 0; k < 128; k++) mram[k] = ram[k];
        exp_fetch.delete(); exp_gap.delete(); exp_out.delete(); exp_wr.delete();
        exp_halt = 0; exp_io[0] = 0; exp_io[1] = 0;
        pc = 0; a = 0; z = 0; c = 0;
        for (int i = 0; i < n; i++) begin
            exp_fetch.push_back(pc);
            op  = int'(rom[pc][11:8]);
            opd = int'(rom[pc][7:0]);
            pc  = (pc + 1) % 32;
            ea  = opd % 128;
            m   = int'(mram[ea]);
            p   = opd % NUM_PORTS;
            exp_gap.push_back((op inside {1, 3, 4, 5, 6, 7}) ? 4 : 3);
            if (op == 15) begin
                exp_halt = 1;
                break;
            end
            case (op)
                1:  a = m;
                2:  a = opd;
                3:  begin mram[ea] = 8'(a); exp_wr.push_back(ea * 256 + a); end
                4:  begin s = a + m; c = (s > 255) ? 1 : 0; a = s % 256; end
                5:  begin c = (a < m) ? 1 : 0; a = (a - m + 256) % 256; end
                6:  a = a & m;
                7:  a = a ^ m;
                8:  a = int'((io_in >> (8 * p)) & 16'hFF);
                9:  begin exp_io[p] = a; exp_out.push_back(p * 256 + a); end
                10: pc = opd % 32;
                11: if (z != 0) pc = opd % 32;
                12: if (c != 0) pc = opd % 32;
                13: begin s = a + opd; c = (s > 255) ? 1 : 0; a = s % 256; end
                default: ;
            endcase
            if (op inside {1, 2, 4, 5, 6, 7, 8, 13}) z = (a == 0) ? 1 : 0;
        end
    endtask

    // One clock: sample outputs at the falling edge and answer bus requests.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (prev_wstb != 2'b00) chk("wstb_one_cycle", io_wstb, 2'b00);
        if (io_wstb != 2'b00) begin
            wstb_cycles++;
            last_wstb = int'(io_wstb);
            chk("wstb_onehot", $onehot(io_wstb), 1);
            for (int k = 0; k < NUM_PORTS; k++)
                if (io_wstb[k]) got_out.push_back(k * 256 + int'(io_out[k*8 +: 8]));
        end
        prev_wstb = io_wstb;

        if (i_pend) chk("imem_req_held", bus.imem_req, 1'b1);
        if (bus.imem_req) begin
            if (!i_pend) begin
                i_pend = 1;
                i_wait = (iw_fix >= 0) ? iw_fix : int'($urandom_range(iw_max, 0));
                i_addr = int'(bus.imem_addr);
            end else begin
                chk("imem_addr_stable", bus.imem_addr, i_addr);
            end
            if (i_wait == 0) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = rom[bus.imem_addr];
                got_fetch.push_back(int'(bus.imem_addr));
                got_fcyc.push_back(cyc);
                i_pend = 0;
            end else begin
                bus.imem_ack  = 1'b0;
                bus.imem_data = 12'($urandom);
                i_wait--;
            end
        end else begin
            bus.imem_ack  = 1'($urandom_range(1, 0));
            bus.imem_data = 12'($urandom);
        end

        if (d_pend) chk("dmem_req_held", bus.dmem_req, 1'b1);
        if (bus.dmem_req) begin
            if (!d_pend) begin
                d_pend = 1;
                d_wait = (dw_fix >= 0) ? dw_fix : int'($urandom_range(dw_max, 0));
                d_addr = int'(bus.dmem_addr);
                d_we   = bus.dmem_we;
            end else begin
                chk("dmem_addr_stable", bus.dmem_addr, d_addr);
                chk("dmem_we_stable", bus.dmem_we, d_we);
            end
            if (d_wait == 0) begin
                bus.dmem_ack = 1'b1;
                if (d_we) begin
                    ram[d_addr] = bus.dmem_wdata;
                    got_wr.push_back(d_addr * 256 + int'(bus.dmem_wdata));
                    bus.dmem_rdata = 8'($urandom);
                end else begin
                    bus.dmem_rdata = ram[d_addr];
                end
                d_pend = 0;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 8'($urandom);
                d_wait--;
            end
        end else begin
            bus.dmem_ack   = 1'($urandom_range(1, 0));
            bus.dmem_rdata = 8'($urandom);
        end
    endtask

    // Reset for two edges with junk acks asserted; checks state after the first edge.
    task automatic do_reset();
        RST = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_data = 12'($urandom);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 8'($urandom);
        @(negedge CLK);
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_pc", bus.imem_addr, 5'd0);
        chk("rst_dmem_req", bus.dmem_req, 1'b0);
        chk("rst_dmem_we", bus.dmem_we, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_io_out", io_out, 16'h0000);
        chk("rst_io_wstb", io_wstb, 2'b00);
        @(negedge CLK);
        RST = 1'b1;
        i_pend = 0; d_pend = 0; prev_wstb = 2'b00;
        wstb_cycles = 0; last_wstb = 0; cyc = 0;
        got_fetch.delete(); got_fcyc.delete(); got_out.delete(); got_wr.delete();
    endtask

    task automatic run_loop(input int n, input int budget);
        for (int t = 0; t < budget; t++) begin
            tick();
            if (halted || got_fetch.size() > n) break;
        end
    endtask

    task automatic compare(input string name, input int n, input bit gaps);
        bit req_seen;
        chk({name, "_halted"}, halted, exp_halt);
        if (exp_halt) begin
            req_seen = 0;
            for (int t = 0; t < 10; t++) begin
                tick();
                if (bus.imem_req || bus.dmem_req || !halted) req_seen = 1;
            end
            chk({name, "_halt_idle"}, req_seen, 1'b0);
            chk({name, "_fetch_cnt"}, got_fetch.size(), exp_fetch.size());
        end else begin
            chk({name, "_progress"}, (got_fetch.size() > n) ? 1 : 0, 1);
        end
        for (int i = 0; i < exp_fetch.size(); i++)
            chk($sformatf("%s_fetch%0d", name, i), at(got_fetch, i), exp_fetch[i]);
        chk({name, "_out_cnt"}, got_out.size(), exp_out.size());
        for (int i = 0; i < exp_out.size(); i++)
            chk($sformatf("%s_out%0d", name, i), at(got_out, i), exp_out[i]);
        chk({name, "_wr_cnt"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            chk($sformatf("%s_wr%0d", name, i), at(got_wr, i), exp_wr[i]);
        chk({name, "_io_out"}, io_out, {8'(exp_io[1]), 8'(exp_io[0])});
        if (gaps)
            for (int i = 1; i < exp_fetch.size(); i++)
                chk($sformatf("%s_lat%0d", name, i),
                    at(got_fcyc, i) - at(got_fcyc, i - 1), exp_gap[i-1]);
    endtask

    task automatic run_prog(input string name, input int n, input bit gaps);
        model_run(n);
        do_reset();
        run_loop(n, 2000);
        compare(name, n, gaps);
    endtask

    task automatic fill_rom(input logic [11:0] w);
        for (int k = 0; k < 32; k++) rom[k] = w;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        io_in = 16'h0000;
        bus.imem_ack = 1'b0; bus.imem_data = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        iw_max = 0; iw_fix = 0; dw_max = 0; dw_fix = 0;
        for (int k = 0; k < 128; k++) ram[k] = 8'($urandom);

        // flags, branches, store/load and subtract-with-borrow, zero-wait memories
        fill_rom(12'hF00);
        rom[0]  = 12'h27F; rom[1]  = 12'hD01; rom[2]  = 12'h900; rom[3]  = 12'hC09;
        rom[4]  = 12'hB09; rom[5]  = 12'hD80; rom[6]  = 12'h901; rom[7]  = 12'hC0A;
        rom[10] = 12'hB0C; rom[12] = 12'h205; rom[13] = 12'h310; rom[14] = 12'h200;
        rom[15] = 12'h110; rom[16] = 12'h900; rom[17] = 12'h203; rom[18] = 12'h510;
        rom[19] = 12'h901; rom[20] = 12'hC1F;
        io_in = 16'h1234;
        run_prog("p1", 40, 1'b1);
        chk("p1_addi_7f_01", at(got_out, 0), 32'h080);
        chk("p1_addi_80_zero", at(got_out, 1), 32'h100);
        chk("p1_sta_write", at(got_wr, 0), 32'h1005);
        chk("p1_lda_value", at(got_out, 2), 32'h005);
        chk("p1_sub_borrow", at(got_out, 3), 32'h1FE);
        chk("p1_jc_to_31", at(got_fetch, 18), 31);

        // PC wrap, INP/OUT channel, imem held off for 3 cycles per fetch
        fill_rom(12'hF00);
        rom[0] = 12'hC04; rom[1] = 12'h2FF; rom[2] = 12'hD01; rom[3] = 12'hA1F;
        rom[4] = 12'h801; rom[5] = 12'h900; rom[31] = 12'h000;
        io_in = 16'hA53C;
        iw_fix = 3; dw_fix = 0;
        run_prog("p2", 40, 1'b0);
        chk("p2_fetch_31", at(got_fetch, 4), 31);
        chk("p2_wrap_to_0", at(got_fetch, 5), 0);
        chk("p2_out_a5", at(got_out, 0), 32'h0A5);
        chk("p2_io_out_lo", io_out[7:0], 8'hA5);
        chk("p2_wstb_value", last_wstb, 1);
        chk("p2_wstb_cycles", wstb_cycles, 1);

        // reset while a store is stalled in MEM
        fill_rom(12'hF00);
        rom[0] = 12'h900; rom[1] = 12'h205; rom[2] = 12'h310;
        ram[16] = 8'h33;
        iw_fix = 0; dw_fix = 1000;
        do_reset();
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 60; t++) begin
                tick();
                if (bus.dmem_req && bus.dmem_we) seen++;
                if (seen == 3) break;
            end
            chk("p3_stall_reached", seen, 3);
        end
        dw_fix = 0;
        model_run(10);
        do_reset();
        run_loop(10, 500);
        compare("p3", 10, 1'b0);
        chk("p3_a_cleared", at(got_out, 0), 32'h000);
        chk("p3_ram_written", ram[16], 8'h05);

        // random programs: two with zero-wait memories (latency checked), four with waits
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                logic [3:0] op;
                op = 4'($urandom_range(14, 0));
                if ($urandom_range(31, 0) == 0) op = 4'hF;
                rom[k] = {op, 8'($urandom)};
            end
            for (int k = 0; k < 128; k++) ram[k] = 8'($urandom);
            io_in = 16'($urandom);
            iw_fix = (r < 2) ? 0 : -1;
            dw_fix = (r < 2) ? 0 : -1;
            iw_max = 3; dw_max = 3;
            run_prog($sformatf("rnd%0d", r), 40, (r < 2) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
